// File: rtl/riscv_pkg.sv
// Shared core-level types: datapath width and the retirement trace record.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head entry is
// visible on data_o whenever count_o is non-zero.
module trace_fifo #(
  parameter int  DEPTH     = 16,
  parameter type payload_t = logic [7:0],
  parameter int  AW        = $clog2(DEPTH),
  parameter int  CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  payload_t      data_i,
  input  logic          pop_i,
  output payload_t      data_o,
  output logic [CW-1:0] count_o
);

  payload_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  // Storage carries no reset; contents are only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_i) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_i)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr_reg];
  assign count_o = count_reg;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retired instructions into a FWFT FIFO for a slow trace sink,
// with x0 data masking, drop accounting and a 64-bit retirement counter.
module commit_trace_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            update_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [4:0]      reg_addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic            clear_i,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [XLEN-1:0] trace_pc_o,
  output logic [XLEN-1:0] trace_instr_o,
  output logic [XLEN-1:0] trace_reg_data_o,
  output logic [4:0]      trace_reg_addr_o,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_o,
  output logic [15:0]     drop_cnt_o,
  output logic [63:0]     instret_o
);

  trace_entry_t  push_entry;
  trace_entry_t  head_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          valid;
  logic          push;
  logic          pop;
  logic          drop;
  logic          overflow_reg;
  logic [15:0]   drop_cnt_reg;
  logic [63:0]   instret_reg;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid && trace_ready_i && !clear_i;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push  = update_i && !clear_i && (!full || pop);
  assign drop  = update_i && !clear_i && full && !pop;

  always_comb begin
    push_entry.pc      = pc_i;
    push_entry.instr   = instr_i;
    push_entry.rd      = reg_addr_i;
    push_entry.rd_data = (reg_addr_i == 5'd0) ? '0 : reg_data_i;
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (trace_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (count)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
      instret_reg  <= '0;
    end else begin
      if (update_i) instret_reg <= instret_reg + 64'd1;
      if (clear_i) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  // Fields read as zero when no entry is present, so reset shows a clean bus.
  assign trace_valid_o    = valid;
  assign trace_pc_o       = valid ? head_entry.pc      : '0;
  assign trace_instr_o    = valid ? head_entry.instr   : '0;
  assign trace_reg_addr_o = valid ? head_entry.rd      : '0;
  assign trace_reg_data_o = valid ? head_entry.rd_data : '0;
  assign count_o          = count;
  assign full_o           = full;
  assign empty_o          = !valid;
  assign overflow_o       = overflow_reg;
  assign drop_cnt_o       = drop_cnt_reg;
  assign instret_o        = instret_reg;

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Downstream consumer of the core's retirement port (`update`/`pc`/`instr`/`reg_addr`/`reg_data`). Captures every retired instruction into a FIFO and drains it over a valid/ready stream toward a trace sink (UART formatter, host mailbox), decoupling the single-cycle commit pulse from a slow consumer. Also keeps a 64-bit retired-instruction counter plus drop/overflow bookkeeping for lossy conditions.

## Interface

- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `XLEN`, `riscv_pkg::XLEN`, datapath width
- `clk_i` in 1 clock, all logic on rising edge
- `rstn_i` in 1 reset, asynchronous, active-low
- `update_i` in 1 core retired one instruction this cycle
- `pc_i` in XLEN PC of retired instruction
- `instr_i` in XLEN instruction word
- `reg_addr_i` in 5 destination register (0 = no writeback)
- `reg_data_i` in XLEN writeback value
- `clear_i` in 1 synchronous flush
- `trace_valid_o` out 1 head entry available
- `trace_ready_i` in 1 sink accepts head entry
- `trace_pc_o`, `trace_instr_o`, `trace_reg_data_o` out XLEN head entry fields
- `trace_reg_addr_o` out 5 head entry rd
- `count_o` out $clog2(DEPTH)+1 occupancy
- `full_o`, `empty_o` out 1 status
- `overflow_o` out 1 sticky: at least one entry dropped
- `drop_cnt_o` out 16 dropped entries, saturating
- `instret_o` out 64 total retirements seen

## Operation

- Push = `update_i` and (not full, or pop in same cycle). Pop = `trace_valid_o && trace_ready_i`.
- Stored entry: `{pc_i, instr_i, reg_addr_i, reg_addr_i==0 ? 0 : reg_data_i}`; x0 data always stored as zero.
- Full, `update_i`=1, no pop: entry dropped; `overflow_o` set; `drop_cnt_o` += 1, holds at 0xFFFF.
- Full, `update_i`=1, pop same cycle: entry accepted, count unchanged.
- Empty, push only: count 0→1. Empty never pops (`trace_valid_o`=0).
- `instret_o` += 1 on every `update_i`, including dropped ones and clear cycles; wraps mod 2^64; never cleared by `clear_i`.
- `clear_i`: priority over push/pop; next cycle pointers = 0, count = 0, `overflow_o` = 0, `drop_cnt_o` = 0. A concurrent `update_i` is not stored and not counted as a drop.
- Output fields are only meaningful while `trace_valid_o`=1; they hold stable while valid and not ready.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty derived from count.

## Timing

- Reset (async assert, sync-to-clock release): count 0, `empty_o`=1, `full_o`=0, `trace_valid_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `instret_o`=0; output data fields 0. Reset mid-stream discards all entries.
- Push latency: entry pushed at edge N is visible on `trace_*` with `trace_valid_o`=1 after edge N (first-word fall-through, no extra cycle).
- Throughput: one push and one pop per cycle sustained.
- `count_o`, `full_o`, `empty_o`, `overflow_o`, `drop_cnt_o`, `instret_o` are registered; update the cycle after the causing edge.
- No combinational path from `trace_ready_i` to `trace_valid_o` or data outputs.

## Structure

- `riscv_pkg` gains `trace_entry_t` packed struct {pc, instr, rd, rd_data} sized from `XLEN`; FIFO storage uses it.
- Sub-module `trace_fifo`: generic synchronous FWFT FIFO (parameter `DEPTH`, payload type), with push/pop/clear/count. Top adds x0 masking, drop logic, counters.

## Test plan

- Reset, 3 commits (pc 0x0/0x4/0x8, rd x1/x0/x2), ready=1 -> three entries out in order, one cycle after each commit; x0 entry rd_data 0; `instret_o`=3.
- ready=0, DEPTH+3 commits -> `full_o`=1, count=DEPTH, `drop_cnt_o`=3, `overflow_o`=1, `instret_o`=DEPTH+3; drain yields first DEPTH entries in order.
- Full, commit with ready=1 same cycle -> no drop, count stays DEPTH, new entry appears last.
- Pointer wrap: 3×DEPTH commits with ready toggling every cycle -> no drops, order preserved.
- `clear_i` with 5 entries and simultaneous commit -> next cycle count 0, `trace_valid_o`=0, overflow/drop cleared, `instret_o` incremented by 1.
- Assert `rstn_i` mid-drain -> all outputs at reset values immediately, no entry emitted after release until a new commit.
